// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : uart_pkg
//  Purpose : Shared definitions for the UART receive path.
//            It holds the receiver FSM state encoding and the serial line
//            levels of the start and stop bits.
//  Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Receiver FSM state encoding. The width is explicit so that every state
  // register has a fixed and known size.
  typedef logic [2:0] rx_state_t;

  localparam rx_state_t RX_IDLE   = 3'd0;
  localparam rx_state_t RX_START  = 3'd1;
  localparam rx_state_t RX_DATA   = 3'd2;
  localparam rx_state_t RX_PARITY = 3'd3;
  localparam rx_state_t RX_STOP   = 3'd4;

  // Serial line levels
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module  : uart_baud_tick
//  Purpose : Oversampled baud tick generator, shared by the transmitter and
//            the receiver. The counter runs from 0 to clk_div and emits a
//            one-cycle tick while it equals clk_div, then reloads to 0.
//            The restart input forces the counter to 0 so that the receiver
//            can align its sampling to a start edge. The transmitter ties
//            restart to 0.
//  Ports   : clk      - system clock
//            reset_n  - synchronous, active-low reset
//            clk_div  - tick period minus 1 (0 gives a tick every clk)
//            restart  - force the counter back to 0
//            tick     - one-cycle baud tick
//  Revision: 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
  parameter int CLK_DIV_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [CLK_DIV_W-1:0] clk_div,
  input  logic                 restart,
  output logic                 tick
);

  logic [CLK_DIV_W-1:0] r_cnt;

  assign tick = (r_cnt == clk_div);

  always_ff @(posedge clk) begin
    if (!reset_n || restart) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CLK_DIV_W'(1);
    end
  end

endmodule : uart_baud_tick
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module  : uart_rx_core
//  Purpose : UART receiver. It synchronises the rx pin and detects the
//            falling edge of a start bit. It samples each bit at its
//            mid-point using an oversampled baud tick, LSB first. Each byte
//            is presented on a valid/ready handshake.
//  Config  : UART_RX_PARITY_EN - when this macro is defined, the receiver
//            adds a parity bit between the data bits and the stop bit.
//            It also adds the ports parity_odd and rx_parity_err.
//  Ports   : clk           - system clock
//            reset_n       - synchronous, active-low reset
//            clk_div       - baud tick period minus 1
//            rx            - asynchronous serial input (idles high)
//            rx_valid      - rx_data holds an unconsumed byte
//            rx_ready      - consumer accepts when rx_valid && rx_ready
//            rx_data       - received byte
//            rx_frame_err  - stop bit of the held byte was sampled 0
//            rx_overrun    - 1-cycle pulse: completed byte dropped
//            rx_busy       - FSM not in IDLE
//            parity_odd    - (parity build) 1 = odd parity, 0 = even parity
//            rx_parity_err - (parity build) parity mismatch of the held byte
//  Revision: 1.0 - initial release
// ============================================================================
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_DIV_W  = 16,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [CLK_DIV_W-1:0] clk_div,
  input  logic                 rx,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_W-1:0]    rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
`ifdef UART_RX_PARITY_EN
  ,
  input  logic                 parity_odd,
  output logic                 rx_parity_err
`endif
);

  localparam int TCNT_W = $clog2(OVERSAMPLE);
  localparam int BCNT_W = $clog2(DATA_W + 1);

  localparam logic [TCNT_W-1:0] c_tcnt_mid  = TCNT_W'(OVERSAMPLE/2 - 1);
  localparam logic [TCNT_W-1:0] c_tcnt_last = TCNT_W'(OVERSAMPLE - 1);
  localparam logic [BCNT_W-1:0] c_bcnt_last = BCNT_W'(DATA_W - 1);

  // Synchroniser and edge detection
  logic r_sync1, r_sync2, r_sync_prev;
  logic w_fall;

  // FSM and counters
  rx_state_t         r_state, w_state_next;
  logic              w_tick, w_mid_tick, w_end_tick;
  logic              w_restart, w_sample_data, w_deliver, w_load;
  logic [TCNT_W-1:0] r_tcnt;
  logic [BCNT_W-1:0] r_bcnt;
  logic [DATA_W-1:0] r_shift;

  // Output holding register
  logic              r_valid, r_ferr, r_ovr;
  logic [DATA_W-1:0] r_data;

  // Baud tick. It is re-aligned on every start edge.
  uart_baud_tick #(
    .CLK_DIV_W (CLK_DIV_W)
  ) u_baud_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_div (clk_div),
    .restart (w_restart),
    .tick    (w_tick)
  );

  // The synchroniser flops reset to the idle line level, so leaving reset
  // never produces a false start edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_sync_prev <= 1'b1;
    end else begin
      r_sync1     <= rx;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
    end
  end

  // A start is only recognised on a 1->0 transition. A line held low (break)
  // therefore cannot retrigger the receiver until the line returns high.
  assign w_fall     = r_sync_prev & ~r_sync2;
  assign w_mid_tick = w_tick && (r_tcnt == c_tcnt_mid);
  assign w_end_tick = w_tick && (r_tcnt == c_tcnt_last);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= RX_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RX_IDLE: begin
        if (w_fall) w_state_next = RX_START;
      end
      RX_START: begin
        if (w_mid_tick) w_state_next = (r_sync2 == START_BIT) ? RX_DATA : RX_IDLE;
      end
      RX_DATA: begin
        if (w_end_tick && (r_bcnt == c_bcnt_last)) begin
`ifdef UART_RX_PARITY_EN
          w_state_next = RX_PARITY;
`else
          w_state_next = RX_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (w_end_tick) w_state_next = RX_STOP;
      end
`endif
      // Leave at mid stop bit so that the next start edge is not missed.
      RX_STOP: begin
        if (w_end_tick) w_state_next = RX_IDLE;
      end
      default: w_state_next = RX_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_restart     = (r_state == RX_IDLE) && w_fall;
    w_sample_data = (r_state == RX_DATA) && w_end_tick;
    w_deliver     = (r_state == RX_STOP) && w_end_tick;
    rx_busy       = (r_state != RX_IDLE);
  end

  // Tick and bit counters, and the shift register. The tick counter restarts
  // on every state change, so each state measures from its own entry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_tcnt  <= '0;
      r_bcnt  <= '0;
      r_shift <= '0;
    end else begin
      if (w_state_next != r_state) begin
        r_tcnt <= '0;
      end else if (w_tick) begin
        r_tcnt <= (r_tcnt == c_tcnt_last) ? '0 : r_tcnt + TCNT_W'(1);
      end

      if (r_state == RX_START) begin
        r_bcnt <= '0;
      end else if (w_sample_data) begin
        r_bcnt <= r_bcnt + BCNT_W'(1);
      end

      // LSB first: shift in at the MSB so the first bit ends at bit 0.
      if (w_sample_data) begin
        r_shift <= {r_sync2, r_shift[DATA_W-1:1]};
      end
    end
  end

  // A completed byte is accepted when the holding register is free, or when
  // the holding register is being emptied in this same cycle.
  assign w_load = w_deliver && (!r_valid || rx_ready);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= w_deliver && !w_load;
      if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= r_shift;
        r_ferr  <= (r_sync2 != STOP_BIT);
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic w_sample_par;
  logic r_par_bit, r_perr;

  assign w_sample_par = (r_state == RX_PARITY) && w_end_tick;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_par_bit <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      if (w_sample_par) r_par_bit <= r_sync2;
      // Expected bit: even parity is ^data; odd parity inverts it.
      if (w_load) r_perr <= (r_par_bit != (^r_shift ^ parity_odd));
    end
  end

  assign rx_parity_err = r_perr;
`endif

  assign rx_valid     = r_valid;
  assign rx_data      = r_data;
  assign rx_frame_err = r_ferr;
  assign rx_overrun   = r_ovr;

endmodule : uart_rx_core
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module  : tb_uart_rx_core
//  Purpose : Directed self-checking bench for uart_rx_core. It runs with
//            clk_div=0 and OVERSAMPLE=16, so each bit lasts 16 clk.
//            Inputs change 2 time units after a rising edge. Outputs are
//            observed on the falling edge.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] clk_div;
  logic        rx;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        rx_frame_err;
  logic        rx_overrun;
  logic        rx_busy;
  logic        parity_odd = 1'b0;
  logic        perr_obs;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          valid_cycles = 0;
  int          ovr_cnt  = 0;
  time         t_start  = 0;
  time         t_rise   = 0;
  logic        prev_valid = 1'b0;
  logic [9:0]  q[$];

  always #5 clk = ~clk;

  uart_rx_core #(
    .CLK_DIV_W  (16),
    .OVERSAMPLE (16),
    .DATA_W     (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clk_div      (clk_div),
    .rx           (rx),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
    .rx_busy      (rx_busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_odd    (parity_odd),
    .rx_parity_err (perr_obs)
`endif
  );

`ifndef UART_RX_PARITY_EN
  assign perr_obs = 1'b0;
`endif

  // Monitor: logs handshakes as {perr, ferr, data} and counts events.
  always @(negedge clk) begin
    if (reset_n) begin
      if (rx_valid && rx_ready) q.push_back({perr_obs, rx_frame_err, rx_data});
      if (rx_valid) valid_cycles++;
      if (rx_valid && !prev_valid) t_rise = $time;
      if (rx_overrun) ovr_cnt++;
    end
    prev_valid = rx_valid;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_byte(input string tag, input logic [7:0] d, input logic ferr, input logic perr);
    logic [9:0] obs;
    obs = (q.size() > 0) ? q.pop_front() : 10'h3FF;
    chk(tag, {22'd0, obs}, {22'd0, perr, ferr, d});
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) step();
  endtask

  // One frame: start bit, 8 data bits LSB first, an optional parity bit,
  // then the stop bit level held for stop_clks.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_clks,
                            input logic par_good);
    t_start = $time;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) drive_bit(d[i], 16);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ parity_odd ^ ~par_good, 16);
`else
    if (!par_good) $display("note: parity flag ignored in 8N1 build");
`endif
    drive_bit(stop, stop_clks);
  endtask

  logic exp_perr_42;

  initial begin
    int lat;
`ifdef UART_RX_PARITY_EN
    exp_perr_42 = 1'b1;
`else
    exp_perr_42 = 1'b0;
`endif
    reset_n  = 1'b0;
    clk_div  = 16'd0;
    rx       = 1'b1;
    rx_ready = 1'b1;

    // Reset state
    repeat (3) step();
    @(negedge clk);
    chk("rst_valid",   {31'd0, rx_valid},     32'd0);
    chk("rst_data",    {24'd0, rx_data},      32'd0);
    chk("rst_ferr",    {31'd0, rx_frame_err}, 32'd0);
    chk("rst_overrun", {31'd0, rx_overrun},   32'd0);
    chk("rst_busy",    {31'd0, rx_busy},      32'd0);
    step();
    reset_n = 1'b1;
    repeat (5) step();

    // 1. 0xA5, rx_ready=1. The stop bit is sampled 9.5 bits after the start
    //    edge (152 clk). The synchroniser, the edge register and the output
    //    register add 3 clk.
    valid_cycles = 0;
    send_frame(8'hA5, 1'b1, 16, 1'b1);
    repeat (16) step();
    @(negedge clk);
    chk("t1_count", q.size(), 32'd1);
    chk_byte("t1_byte", 8'hA5, 1'b0, 1'b0);
    chk("t1_valid_cycles", valid_cycles, 32'd1);
    lat = int'((t_rise - t_start) / 10);
    chk("t1_latency", lat, 32'd155);
    step();

    // 2. Glitch: low for 4 clk. The receiver is rejected at mid start bit.
    rx = 1'b0;
    repeat (4) step();
    rx = 1'b1;
    @(negedge clk);
    chk("t2_busy_during", {31'd0, rx_busy}, 32'd1);
    repeat (20) step();
    @(negedge clk);
    chk("t2_busy_after", {31'd0, rx_busy}, 32'd0);
    chk("t2_no_byte", q.size(), 32'd0);
    step();

    // 3. 0x3C with stop bit 0, then the line stays low for a long time.
    send_frame(8'h3C, 1'b0, 16 * 12, 1'b1);
    @(negedge clk);
    chk_byte("t3_byte_ferr", 8'h3C, 1'b1, 1'b0);
    chk("t3_no_more", q.size(), 32'd0);
    step();
    drive_bit(1'b1, 48);

    // 4. Overrun: rx_ready=0, send 0x11 then 0x22.
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 16, 1'b1);
    send_frame(8'h22, 1'b1, 16, 1'b1);
    repeat (8) step();
    @(negedge clk);
    chk("t4_valid_held", {31'd0, rx_valid}, 32'd1);
    chk("t4_data_held",  {24'd0, rx_data},  32'h11);
    chk("t4_overrun",    ovr_cnt,           32'd1);
    chk("t4_no_hs",      q.size(),          32'd0);
    step();
    rx_ready = 1'b1;
    step();
    @(negedge clk);
    chk_byte("t4_byte", 8'h11, 1'b0, 1'b0);
    chk("t4_valid_clr", {31'd0, rx_valid}, 32'd0);
    step();

    // 5. Back-to-back frames with a single stop bit.
    send_frame(8'h00, 1'b1, 16, 1'b1);
    send_frame(8'hFF, 1'b1, 16, 1'b1);
    send_frame(8'h55, 1'b1, 16, 1'b1);
    repeat (16) step();
    @(negedge clk);
    chk("t5_count", q.size(), 32'd3);
    chk_byte("t5_b0", 8'h00, 1'b0, 1'b0);
    chk_byte("t5_b1", 8'hFF, 1'b0, 1'b0);
    chk_byte("t5_b2", 8'h55, 1'b0, 1'b0);
    chk("t5_overrun", ovr_cnt, 32'd1);
    step();

    // 6. Reset in the middle of the data bits of 0x77, then a clean 0x42
    //    (with bad parity in the parity build).
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h77 >> i), 16);
    reset_n = 1'b0;
    rx = 1'b1;
    step();
    @(negedge clk);
    chk("t6_busy_rst",  {31'd0, rx_busy},  32'd0);
    chk("t6_valid_rst", {31'd0, rx_valid}, 32'd0);
    step();
    reset_n = 1'b1;
    repeat (32) step();
    send_frame(8'h42, 1'b1, 16, 1'b0);
    repeat (16) step();
    @(negedge clk);
    chk("t6_count", q.size(), 32'd1);
    chk_byte("t6_byte", 8'h42, 1'b0, exp_perr_42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart_rx_core
`default_nettype wire
